// File: rtl/fp_sqrt_arbiter_if.sv
// Request/response bundle between float consumers and the shared square-root arbiter.
// The master drives requests and grant enable; the slave returns grants and tagged results.
interface fp_sqrt_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 3
);
  logic                   en;
  logic [NUM_REQ-1:0]     req_valid;
  logic [32*NUM_REQ-1:0]  req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     resp_valid;
  logic [31:0]            resp_data;
  logic [TAG_W-1:0]       resp_tag;
  logic                   busy;

  modport master (
    output en, req_valid, req_data,
    input  req_ready, resp_valid, resp_data, resp_tag, busy
  );

  modport slave (
    input  en, req_valid, req_data,
    output req_ready, resp_valid, resp_data, resp_tag, busy
  );
endinterface

// File: rtl/fp_sqrt_arbiter.sv
// Round-robin sharing of one combinational approximate float square root between NUM_REQ
// requesters, with IEEE-754 special-case handling and a fixed two-register pipeline.
module approx_fp_sqrt (
  input  logic [31:0] i_op,
  output logic [31:0] o_res
);
  // Exponent halving plus bias re-centring; exact at powers of four, within ~6.1% above elsewhere.
  assign o_res = (i_op >> 1) + 32'h1FC0_0000;
endmodule

module fp_sqrt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 3
) (
  input logic              clk,
  input logic              rst_n,
  fp_sqrt_arbiter_if.slave bus
);

  typedef enum logic [2:0] {CLS_NORM, CLS_ZERO, CLS_NEG, CLS_INF, CLS_NAN} cls_t;

  function automatic cls_t classify(input logic [31:0] op);
    cls_t c;
    if (op[30:23] == 8'd0)                               c = CLS_ZERO;
    else if (op[31])                                     c = CLS_NEG;
    else if (op[30:23] == 8'hFF && op[22:0] == 23'd0)    c = CLS_INF;
    else if (op[30:23] == 8'hFF)                         c = CLS_NAN;
    else                                                 c = CLS_NORM;
    return c;
  endfunction

  function automatic logic [31:0] sqrt_special(input cls_t cls, input logic [31:0] op,
                                               input logic [31:0] approx);
    logic [31:0] r;
    case (cls)
      CLS_ZERO:         r = {op[31], 31'b0};
      CLS_NEG, CLS_NAN: r = 32'h7FC0_0000;
      CLS_INF:          r = 32'h7F80_0000;
      default:          r = approx;
    endcase
    return r;
  endfunction

  logic [TAG_W-1:0]   r_last;
  logic [TAG_W-1:0]   w_sel;
  logic               w_found;
  logic               w_xfer;
  logic [31:0]        w_op_p0;
  logic [NUM_REQ-1:0] w_onehot_p0;

  logic               r_vld_p1;
  logic [TAG_W-1:0]   r_tag_p1;
  logic [31:0]        r_op_p1;
  cls_t               r_cls_p1;
  logic [31:0]        w_approx_p1;

  logic               r_vld_p2;
  logic [TAG_W-1:0]   r_tag_p2;
  logic [31:0]        r_data_p2;

  // Stage 0: pick the valid requester closest after r_last, wrapping modulo NUM_REQ.
  always_comb begin
    int best;
    int d;
    best    = NUM_REQ;
    d       = 0;
    w_sel   = '0;
    w_found = 1'b0;
    w_op_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i - int'(r_last) - 1;
      if (d < 0) d = d + NUM_REQ;
      if (bus.req_valid[i] && d < best) begin
        best    = d;
        w_sel   = i[TAG_W-1:0];
        w_found = 1'b1;
        w_op_p0 = bus.req_data[32*i +: 32];
      end
    end
  end

  assign w_xfer        = w_found & bus.en & rst_n;
  assign w_onehot_p0   = NUM_REQ'(1) << w_sel;
  assign bus.req_ready = w_xfer ? w_onehot_p0 : '0;

  // Stage 1: accepted operand, owner and class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last   <= TAG_W'(NUM_REQ - 1);
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_xfer;
      if (w_xfer) r_last <= w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_tag_p1 <= w_sel;
      r_op_p1  <= w_op_p0;
      r_cls_p1 <= classify(w_op_p0);
    end
  end

  approx_fp_sqrt u_sqrt (
    .i_op  (r_op_p1),
    .o_res (w_approx_p1)
  );

  // Stage 2: special-case mux result; reloads every cycle, so it holds while stage 1 holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_tag_p2  <= '0;
      r_data_p2 <= '0;
    end else begin
      r_vld_p2  <= r_vld_p1;
      r_tag_p2  <= r_tag_p1;
      r_data_p2 <= sqrt_special(r_cls_p1, r_op_p1, w_approx_p1);
    end
  end

  assign bus.resp_valid = r_vld_p2 ? (NUM_REQ'(1) << r_tag_p2) : '0;
  assign bus.resp_data  = r_data_p2;
  assign bus.resp_tag   = r_tag_p2;
  assign bus.busy       = r_vld_p1 | r_vld_p2;

endmodule

// File: tb/tb_fp_sqrt_arbiter.sv
// Bench for fp_sqrt_arbiter: directed tables and sequences plus random traffic
// checked every cycle against a queue-based grant/result model.
module tb_fp_sqrt_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fp_sqrt_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

  fp_sqrt_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; int tag; logic [31:0] op; } exp_t;
  exp_t q[$];
  int   m_last = NUM_REQ - 1;
  int   resp_cnt[NUM_REQ];

  typedef struct { logic [31:0] op; logic [31:0] exp; bit exact; } vec_t;
  localparam int NV = 12;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic real f2r(input logic [31:0] b);
    int  e;
    real m;
    e = int'(b[30:23]);
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    return m * (2.0 ** (e - 127));
  endfunction

  // Approximate result must be a positive normal within [-0.1%, +7%] of the true root.
  task automatic chk_norm(input string name, input logic [31:0] op, input logic [31:0] got);
    real r;
    n_cmp++;
    r = f2r(got) / $sqrt(f2r(op));
    if (got[31] || got[30:23] == 8'd0 || got[30:23] == 8'hFF || r < 0.999 || r > 1.07) begin
      n_bad++;
      $display("FAIL %s: got %h for operand %h, ratio to true sqrt %f (need 0.999..1.07)",
               name, got, op, r);
    end
  endtask

  task automatic chk_result(input string name, input logic [31:0] op, input logic [31:0] got);
    if (op[30:23] == 8'd0)                            chk(name, got, {op[31], 31'b0});
    else if (op[31])                                  chk(name, got, 32'h7FC0_0000);
    else if (op[30:23] == 8'hFF && op[22:0] != 23'd0) chk(name, got, 32'h7FC0_0000);
    else if (op[30:23] == 8'hFF)                      chk(name, got, 32'h7F80_0000);
    else                                              chk_norm(name, op, got);
  endtask

  // Reference model, evaluated once per cycle away from the active edge.
  always @(negedge clk) begin
    int  g;
    bit  found;
    bit  exp_busy;
    exp_t e;
    if (!rst_n) begin
      chk("rst_req_ready", bus.req_ready, '0);
      chk("rst_resp_valid", bus.resp_valid, '0);
      chk("rst_resp_data", bus.resp_data, '0);
      chk("rst_resp_tag", bus.resp_tag, '0);
      chk("rst_busy", bus.busy, '0);
      q.delete();
      m_last = NUM_REQ - 1;
      for (int i = 0; i < NUM_REQ; i++) resp_cnt[i] = 0;
    end else begin
      exp_busy = 1'b0;
      foreach (q[k]) if (q[k].due == cyc || q[k].due == cyc + 1) exp_busy = 1'b1;
      chk("busy", bus.busy, exp_busy);
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("resp_valid", bus.resp_valid, 32'(1 << e.tag));
        chk("resp_tag", bus.resp_tag, e.tag);
        chk_result("resp_data", e.op, bus.resp_data);
      end else begin
        chk("resp_idle", bus.resp_valid, '0);
      end
      for (int i = 0; i < NUM_REQ; i++) if (bus.resp_valid[i]) resp_cnt[i]++;
      found = 1'b0;
      g = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int idx;
        idx = (m_last + k) % NUM_REQ;
        if (!found && bus.en && bus.req_valid[idx]) begin
          found = 1'b1;
          g = idx;
        end
      end
      chk("req_ready", bus.req_ready, found ? 32'(1 << g) : 32'd0);
      if (found) begin
        e.due = cyc + 2;
        e.tag = g;
        e.op  = bus.req_data[32*g +: 32];
        q.push_back(e);
        m_last = g;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] v);
    bus.req_data[32*i +: 32] = v;
  endtask

  function automatic logic [31:0] rand_norm();
    return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] sp[6];
    sp[0] = 32'h7F80_0000; sp[1] = 32'hFF80_0000; sp[2] = 32'h7FC0_0001;
    sp[3] = 32'h8000_0000; sp[4] = 32'h0000_0000; sp[5] = 32'hC080_0000;
    case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return sp[$urandom_range(0, 5)];
      2:       return {1'($urandom), 8'd0, 23'($urandom)};
      default: return rand_norm();
    endcase
  endfunction

  logic [NUM_REQ-1:0] gseen[12];

  initial begin
    bus.en        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    tbl[0]  = '{32'hC080_0000, 32'h7FC0_0000, 1'b1};
    tbl[1]  = '{32'h8000_0000, 32'h8000_0000, 1'b1};
    tbl[2]  = '{32'h0000_0001, 32'h0000_0000, 1'b1};
    tbl[3]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b1};
    tbl[4]  = '{32'h7FC0_0001, 32'h7FC0_0000, 1'b1};
    tbl[5]  = '{32'hFF80_0000, 32'h7FC0_0000, 1'b1};
    tbl[6]  = '{32'h807F_FFFF, 32'h8000_0000, 1'b1};
    tbl[7]  = '{32'hFFC0_0000, 32'h7FC0_0000, 1'b1};
    tbl[8]  = '{32'h4080_0000, 32'h4000_0000, 1'b0};
    tbl[9]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b0};
    tbl[10] = '{32'h41C8_0000, 32'h40A0_0000, 1'b0};
    tbl[11] = '{32'h3E80_0000, 32'h3F00_0000, 1'b0};

    #1 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    bus.en = 1'b1;

    // Single request from requester 2.
    set_op(2, 32'h4080_0000);
    bus.req_valid = 4'b0100;
    @(negedge clk); chk("single_grant", bus.req_ready, 4'b0100);
    tick(); bus.req_valid = '0;
    @(negedge clk); chk("single_busy1", bus.busy, 1); chk("single_early", bus.resp_valid, 0);
    tick();
    @(negedge clk);
    chk("single_valid", bus.resp_valid, 4'b0100);
    chk("single_tag", bus.resp_tag, 2);
    chk("single_busy2", bus.busy, 1);
    n_cmp++;
    if (bus.resp_data < 32'h3FF0_0000 || bus.resp_data > 32'h4008_0000) begin
      n_bad++;
      $display("FAIL single_range: got %h expected 3ff00000..40080000", bus.resp_data);
    end
    tick();
    @(negedge clk); chk("single_busy_end", bus.busy, 0);

    // Vector table, one requester at a time.
    for (int t = 0; t < NV; t++) begin
      set_op(t % 4, tbl[t].op);
      bus.req_valid = 4'(1 << (t % 4));
      tick(); bus.req_valid = '0;
      tick();
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", t), bus.resp_valid, 32'(1 << (t % 4)));
      if (tbl[t].exact) chk($sformatf("tbl%0d_data", t), bus.resp_data, tbl[t].exp);
      else              chk_norm($sformatf("tbl%0d_data", t), tbl[t].op, bus.resp_data);
      tick();
    end

    // Fairness from reset: all requesters valid for 12 cycles.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, rand_norm());
    bus.req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); gseen[k] = bus.req_ready;
      tick();
    end
    bus.req_valid = '0;
    tick(); tick(); tick();
    for (int k = 0; k < 12; k++) chk($sformatf("fair_grant%0d", k), gseen[k], 32'(1 << (k % 4)));
    for (int i = 0; i < NUM_REQ; i++) chk($sformatf("fair_count%0d", i), resp_cnt[i], 3);

    // Wrap and skip: only 1 and 3 valid, pointer at 3.
    bus.req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); gseen[k] = bus.req_ready;
      tick();
    end
    bus.req_valid = '0;
    for (int k = 0; k < 4; k++)
      chk($sformatf("wrap_grant%0d", k), gseen[k], (k % 2 == 0) ? 4'b0010 : 4'b1000);
    tick(); tick(); tick();

    // Drain: two in flight, then en low.
    bus.req_valid = '1;
    tick(); tick();
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk($sformatf("drain_ready%0d", k), bus.req_ready, 0);
      if (k == 2) chk("drain_busy_low", bus.busy, 0);
      tick();
    end
    bus.en = 1'b1;
    @(negedge clk); chk("drain_resume", bus.req_ready, 4'b0100);
    tick(); bus.req_valid = '0;
    tick(); tick(); tick();

    // Reset mid-flight.
    set_op(0, 32'h4180_0000);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", bus.req_ready, 0);
    chk("midrst_busy", bus.busy, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_first_grant", bus.req_ready, 4'b0001);
    chk("midrst_no_resp", bus.resp_valid, 0);
    tick(); bus.req_valid = '0;
    tick(); tick(); tick();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      bus.req_valid = 4'($urandom);
      for (int i = 0; i < NUM_REQ; i++) if ($urandom_range(0, 1) == 1) set_op(i, rand_op());
      tick();
    end
    bus.en = 1'b1;
    bus.req_valid = '0;
    tick(); tick(); tick(); tick();
    @(negedge clk); chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
